reserved_gate_controller: RTL

RESERVED_GATE_CONTROLLER -- requirements
Module: reserved_gate_controller

---
 rtl/reserved_gate_controller_if.sv | 29 ++
 rtl/reserved_gate_controller.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/reserved_gate_controller_if.sv
// Request/response and gate-sensor bundle for the reserved-parking gate controller.
// slave = controller side, master = requester/environment side.
interface reserved_gate_controller_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N) + 1;

  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_flat;
  logic         req_pwd_ok;
  logic         req_exit;
  logic         car_passed;
  logic         gate_open;
  logic         resp_valid;
  logic [2:0]   resp_code;
  logic [N:0]   occupied;
  logic [W:0]   free_count;

  modport slave (
    input  req_valid, req_flat, req_pwd_ok, req_exit, car_passed,
    output req_ready, gate_open, resp_valid, resp_code, occupied, free_count
  );

  modport master (
    output req_valid, req_flat, req_pwd_ok, req_exit, car_passed,
    input  req_ready, gate_open, resp_valid, resp_code, occupied, free_count
  );
endinterface

// File: rtl/reserved_gate_controller.sv
// Reserved-slot gate controller: validates entry/exit requests per flat, opens the
// gate, tracks slot occupancy and reports one response per request.
//
// state | meaning
// IDLE  | ready for a request
// CHECK | one cycle evaluating the captured request
// OPEN  | gate open, waiting for car_passed or timeout
// CLOSE | one cycle with gate closed before returning to IDLE
module reserved_gate_controller #(
  parameter int N           = 8,
  parameter int OPEN_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  reserved_gate_controller_if.slave bus
);
  localparam int W = $clog2(N) + 1;
  localparam int S = N + 1;
  localparam logic [7:0] CNT_LAST = 8'(OPEN_CYCLES - 1);

  localparam logic [2:0] RC_ENTRY   = 3'd0;
  localparam logic [2:0] RC_EXIT    = 3'd1;
  localparam logic [2:0] RC_BADFLAT = 3'd2;
  localparam logic [2:0] RC_BADPWD  = 3'd3;
  localparam logic [2:0] RC_ALREADY = 3'd4;
  localparam logic [2:0] RC_NOTIN   = 3'd5;
  localparam logic [2:0] RC_TIMEOUT = 3'd6;

  typedef enum logic [1:0] {IDLE, CHECK, OPEN, CLOSE} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] flat_q, flat_d;
  logic         pwd_q, pwd_d;
  logic         exit_q, exit_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         gate_q, gate_d;
  logic         resp_valid_q, resp_valid_d;
  logic [2:0]   resp_code_q, resp_code_d;
  logic [S-1:0] occ_q, occ_d;
  logic [W:0]   free_q, free_d;

  logic         ready;
  logic         accept;
  logic [S-1:0] slot_sel;
  logic         slot_set;
  logic         bad_flat;
  logic [W:0]   ones;

  assign ready  = (state_q == IDLE) && rst_n;
  assign accept = bus.req_valid && ready;

  always_comb begin
    slot_sel = '0;
    for (int k = 0; k < S; k++) begin
      if (flat_q == W'(k + 1)) slot_sel[k] = 1'b1;
    end
  end

  assign bad_flat = (flat_q == '0) || (flat_q > W'(S));
  assign slot_set = |(occ_q & slot_sel);

  always_comb begin
    state_d      = state_q;
    flat_d       = flat_q;
    pwd_d        = pwd_q;
    exit_d       = exit_q;
    cnt_d        = cnt_q;
    gate_d       = gate_q;
    resp_valid_d = 1'b0;
    resp_code_d  = resp_code_q;
    occ_d        = occ_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          flat_d  = bus.req_flat;
          pwd_d   = bus.req_pwd_ok;
          exit_d  = bus.req_exit;
          state_d = CHECK;
        end
      end
      CHECK: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
        if (bad_flat)                 resp_code_d = RC_BADFLAT;
        else if (!exit_q && !pwd_q)   resp_code_d = RC_BADPWD;
        else if (!exit_q && slot_set) resp_code_d = RC_ALREADY;
        else if (exit_q && !slot_set) resp_code_d = RC_NOTIN;
        else begin
          state_d      = OPEN;
          resp_valid_d = 1'b0;
          gate_d       = 1'b1;
          cnt_d        = '0;
        end
      end
      OPEN: begin
        // a car clearing the gate on the last open cycle wins over the timeout
        if (bus.car_passed) begin
          occ_d        = exit_q ? (occ_q & ~slot_sel) : (occ_q | slot_sel);
          gate_d       = 1'b0;
          state_d      = CLOSE;
          resp_valid_d = 1'b1;
          resp_code_d  = exit_q ? RC_EXIT : RC_ENTRY;
        end else if (cnt_q == CNT_LAST) begin
          gate_d       = 1'b0;
          state_d      = CLOSE;
          resp_valid_d = 1'b1;
          resp_code_d  = RC_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      CLOSE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ones = '0;
    for (int k = 0; k < S; k++) ones = ones + (W+1)'(occ_d[k]);
    free_d = (W+1)'(S) - ones;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      flat_q       <= '0;
      pwd_q        <= 1'b0;
      exit_q       <= 1'b0;
      cnt_q        <= '0;
      gate_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_code_q  <= '0;
      occ_q        <= '0;
      free_q       <= (W+1)'(S);
    end else begin
      state_q      <= state_d;
      flat_q       <= flat_d;
      pwd_q        <= pwd_d;
      exit_q       <= exit_d;
      cnt_q        <= cnt_d;
      gate_q       <= gate_d;
      resp_valid_q <= resp_valid_d;
      resp_code_q  <= resp_code_d;
      occ_q        <= occ_d;
      free_q       <= free_d;
    end
  end

  assign bus.req_ready  = ready;
  assign bus.gate_open  = gate_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_code  = resp_code_q;
  assign bus.occupied   = occ_q;
  assign bus.free_count = free_q;
endmodule
